// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the execute stage and muldiv
// Ports (slave view):
//   start  in   request, sampled only while busy=0
//   flush  in   synchronous abort of the operation in flight
//   ctrl   in   RV32M funct3 (000 MUL .. 111 REMU)
//   A, B   in   rs1 / rs2 operands
//   busy   out  operation in flight
//   done   out  one-cycle result pulse
//   res    out  result, held until the next done
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      ctrl;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  modport master (
    output start, flush, ctrl, A, B,
    input  busy, done, res
  );

  modport slave (
    input  start, flush, ctrl, A, B,
    output busy, done, res
  );
endinterface

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of muldiv_if (start/flush/ctrl/A/B in, busy/done/res out)
// Every operation takes 34 edges from the accepting edge to res being visible:
// one load edge, 32 iteration edges, one fix-up edge.
module muldiv #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              bzero_q, bzero_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  // Operand conditioning at the accepting edge
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (bus.ctrl == OP_MULH) || (bus.ctrl == OP_MULHSU) ||
               (bus.ctrl == OP_DIV)  || (bus.ctrl == OP_REM);
    b_signed = (bus.ctrl == OP_MULH) || (bus.ctrl == OP_DIV) || (bus.ctrl == OP_REM);
    a_neg    = a_signed & bus.A[XLEN-1];
    b_neg    = b_signed & bus.B[XLEN-1];
    a_mag    = a_neg ? (~bus.A + 1'b1) : bus.A;
    b_mag    = b_neg ? (~bus.B + 1'b1) : bus.B;
  end

  // One iteration of each algorithm
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_trial, div_diff;
  logic          div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Remainder shifted left with the next dividend bit; needs XLEN+1 bits.
    div_trial = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opb_q};
    div_ge    = ~div_diff[XLEN];
  end

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    mul_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fin_res = mul_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = mul_fix[2*XLEN-1:XLEN];
      // Divide by zero must return all ones regardless of the dividend sign.
      // Signed overflow needs no special case: |0x80000000|/1 negated is 0x80000000, remainder 0.
      OP_DIV, OP_DIVU:               fin_res = bzero_q ? '1 : quo_fix;
      // With a zero divisor the remainder register ends holding |A|; re-signing yields A.
      default:                       fin_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    bzero_d = bzero_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d = S_CALC;
          op_d    = bus.ctrl;
          neg_d   = (bus.ctrl == OP_REM) ? a_neg : (a_neg ^ b_neg);
          bzero_d = (bus.B == '0);
          cnt_d   = '0;
          if (bus.ctrl[2]) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {{XLEN{1'b0}}, b_mag};
            opb_d = a_mag;
          end
        end
      end

      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          res_d  = fin_res;
          done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      neg_q   <= neg_d;
      bzero_q <= bzero_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.res  = res_q;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - self-checking bench for muldiv
module tb_muldiv;

  logic clk;
  logic rst_n;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Architectural result of one RV32M operation
  function automatic logic [31:0] ref_op(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        p;
    logic signed [31:0] q;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    q   = '0;
    case (c)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Behavioural timing model: an accepted request completes 34 edges after acceptance.
  int          m_left;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.flush) begin
        m_left <= 0;
      end else if (m_left == 0) begin
        if (bus.start) begin
          m_left <= 33;
          m_pend <= ref_op(bus.ctrl, bus.A, bus.B);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end
  end

  // Literal expectations armed by the stimulus: 1 = res at done, 2 = res held with no done
  int          lit_mode = 0;
  logic [31:0] lit_exp  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      if (err_cnt <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    check("busy", 32'(bus.busy), 32'(m_left != 0));
    check("done", 32'(bus.done), 32'(m_done));
    check("res",  bus.res, m_res);
    if (lit_mode == 1 && bus.done) check("lit_res", bus.res, lit_exp);
    if (lit_mode == 2) begin
      check("lit_hold_res", bus.res, lit_exp);
      check("lit_no_done", 32'(bus.done), 32'd0);
    end
  end

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Starts one operation at the current negedge and returns at the negedge of its done cycle.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int n;
    lit_mode  = 1;
    lit_exp   = exp;
    bus.start = 1'b1;
    bus.ctrl  = c;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.ctrl  = 3'($urandom_range(0, 7));
    n = 1;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    lit_mode = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.ctrl  = '0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001);
    run_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op(3'd7, 32'd5,         32'd0,         32'h0000_0005);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    repeat (2) @(negedge clk);

    // Second start sampled at E5 must be dropped
    lit_mode  = 1;
    lit_exp   = 32'd14;
    bus.start = 1'b1;
    bus.ctrl  = 3'd5;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    for (int k = 1; k <= 45 && !(k > 1 && bus.done); k++) begin
      @(negedge clk);
      bus.start = (k == 5);
      if (k == 5) begin
        bus.ctrl = 3'd0;
        bus.A    = 32'd3;
        bus.B    = 32'd4;
      end
    end
    lit_mode = 0;

    // Back-to-back: start issued in the done cycle of the previous operation
    run_op(3'd7, 32'd100,  32'd7,    32'd2);
    run_op(3'd0, 32'd1000, 32'd1000, 32'h000F_4240);
    run_op(3'd0, 32'd9,    32'd9,    32'd81);
    run_op(3'd0, 32'd1000, 32'd1000, 32'h000F_4240);
    repeat (2) @(negedge clk);

    // Flush sampled at E10: no done, res keeps 0xF4240
    bus.start = 1'b1;
    bus.ctrl  = 3'd4;
    bus.A     = 32'd50;
    bus.B     = 32'd5;
    lit_mode  = 2;
    lit_exp   = 32'h000F_4240;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = (k == 10);
    end
    lit_mode = 0;

    // Asynchronous reset just after E20
    bus.start = 1'b1;
    bus.ctrl  = 3'd0;
    bus.A     = 32'd6;
    bus.B     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    lit_mode = 2;
    lit_exp  = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lit_mode = 0;
    run_op(3'd0, 32'd3, 32'd4, 32'd12);

    // Randomized traffic, including starts while busy and occasional flushes
    repeat (4000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 59) == 0);
      bus.ctrl  = 3'($urandom_range(0, 7));
      bus.A     = rnd_val();
      bus.B     = rnd_val();
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
